// File: rtl/sram_resp_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_resp_tracker_if
// Description : Bundles the upstream (pipeline-side) and downstream
//               (SRAM-bridge-side) req/addr_ok/data_ok channel signals seen
//               by sram_resp_tracker.
//               slave  : the tracker itself.
//               master : the environment around it (pipeline stage driving
//                        up_* requests and the SRAM bridge driving responses).
// Parameters  : TAG_W - width of per-request metadata.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_resp_tracker_if #(
  parameter int TAG_W = 2
);
  // upstream request side
  logic             up_req;
  logic             up_wr;
  logic [1:0]       up_size;
  logic [31:0]      up_addr;
  logic [3:0]       up_wstrb;
  logic [31:0]      up_wdata;
  logic [TAG_W-1:0] up_tag;
  logic             up_addr_ok;
  logic             up_data_ok;
  logic [31:0]      up_rdata;
  logic [TAG_W-1:0] up_rsp_tag;
  // downstream SRAM side
  logic             sram_req;
  logic             sram_wr;
  logic [1:0]       sram_size;
  logic [31:0]      sram_addr;
  logic [3:0]       sram_wstrb;
  logic [31:0]      sram_wdata;
  logic             sram_addr_ok;
  logic             sram_data_ok;
  logic [31:0]      sram_rdata;

  modport slave (
    input  up_req, up_wr, up_size, up_addr, up_wstrb, up_wdata, up_tag,
    input  sram_addr_ok, sram_data_ok, sram_rdata,
    output up_addr_ok, up_data_ok, up_rdata, up_rsp_tag,
    output sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata
  );

  modport master (
    output up_req, up_wr, up_size, up_addr, up_wstrb, up_wdata, up_tag,
    output sram_addr_ok, sram_data_ok, sram_rdata,
    input  up_addr_ok, up_data_ok, up_rdata, up_rsp_tag,
    input  sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_resp_tracker.sv
`default_nettype none
// ============================================================================
// Module      : sram_resp_tracker
// Description : In-flight tracker for one SRAM-like req/addr_ok/data_ok
//               channel. Counts accepted-but-unanswered requests, keeps the
//               issuing tag of each in an in-order FIFO, and on a pipeline
//               flush drops every response still owed to flushed requests.
//               Surviving responses are returned with their request's tag.
// Ports       : clk, reset (sync, active-high), flush
//               bus         - sram_resp_tracker_if.slave (up_* and sram_*)
//               outstanding - current in-flight count
//               discarding  - responses to flushed requests still pending
//               proto_err   - sticky: data_ok seen with nothing outstanding
//               stat_issued / stat_discarded - only with the macro below
// Options     : `define RESP_TRACKER_STATS_EN adds the two 32-bit statistics
//               counters (requests issued, responses suppressed).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_resp_tracker #(
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int TAG_W           = 2,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  sram_resp_tracker_if.slave    bus,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  discarding,
  output logic                  proto_err
`ifdef RESP_TRACKER_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_discarded
`endif
);

  localparam int                 c_ptr_w    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(MAX_OUTSTANDING - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [CNT_W-1:0]   c_max_cnt  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_discard_cnt;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic               r_proto_err;
  logic [TAG_W-1:0]   r_tag_mem [MAX_OUTSTANDING];

  logic w_full;
  logic w_req_fire;
  logic w_rsp_fire;
  logic w_rsp_keep;

  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : (p + c_ptr_one);
  endfunction

  // full comes only from registered state, so sram_data_ok never reaches
  // sram_req combinationally; a response at full frees the slot next cycle.
  assign w_full     = (r_outstanding == c_max_cnt);
  assign w_req_fire = bus.sram_req & bus.sram_addr_ok;
  // A data_ok with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_fire = bus.sram_data_ok & (r_outstanding != '0);
  // Responses owed to flushed requests, and any response landing in the
  // flush cycle itself, are swallowed here.
  assign w_rsp_keep = w_rsp_fire & (r_discard_cnt == '0) & ~flush;

  assign bus.sram_req   = bus.up_req & ~w_full & ~flush;
  assign bus.up_addr_ok = bus.sram_addr_ok & ~w_full & ~flush;
  assign bus.sram_wr    = bus.up_wr;
  assign bus.sram_size  = bus.up_size;
  assign bus.sram_addr  = bus.up_addr;
  assign bus.sram_wstrb = bus.up_wstrb;
  assign bus.sram_wdata = bus.up_wdata;

  assign bus.up_data_ok = w_rsp_keep;
  assign bus.up_rdata   = bus.sram_rdata;
  assign bus.up_rsp_tag = r_tag_mem[r_rd_ptr];

  assign outstanding = r_outstanding;
  assign discarding  = (r_discard_cnt != '0);
  assign proto_err   = r_proto_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
      r_discard_cnt <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_fire);
      if (w_req_fire) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_rsp_fire) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      // On flush every request still in flight becomes a discard, except a
      // response consumed this very cycle. Re-flushing simply re-derives the
      // count because outstanding already covers earlier flushed requests.
      if (flush) begin
        r_discard_cnt <= r_outstanding - CNT_W'(w_rsp_fire);
      end else if (w_rsp_fire && (r_discard_cnt != '0)) begin
        r_discard_cnt <= r_discard_cnt - c_cnt_one;
      end
      if (bus.sram_data_ok && (r_outstanding == '0)) r_proto_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_tag_mem[r_wr_ptr] <= bus.up_tag;
  end

`ifdef RESP_TRACKER_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_discarded;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_issued    <= '0;
      r_stat_discarded <= '0;
    end else begin
      if (w_req_fire)               r_stat_issued    <= r_stat_issued + 32'd1;
      if (w_rsp_fire & ~w_rsp_keep) r_stat_discarded <= r_stat_discarded + 32'd1;
    end
  end

  assign stat_issued    = r_stat_issued;
  assign stat_discarded = r_stat_discarded;
`endif

endmodule
`default_nettype wire
